even_odd_code: RTL and testbench

EVEN_ODD_CODE -- requirements
Module: even_odd_code

---
 rtl/even_odd_pkg.sv | 8 +
 rtl/even_odd_code_sat_counter.sv | 27 ++
 rtl/even_odd_code.sv | 67 ++++++
 tb/tb_even_odd_code.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/even_odd_pkg.sv
// Shared defaults for the even/odd classifier.
// Holds operand and counter widths used by even_odd_code.
package even_odd_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/even_odd_code_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n, inc, clr (clr wins over inc), cnt.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic full;

  assign full = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/even_odd_code.sv
// Registered even/odd classifier with per-class saturating counters.
// Ports: clk, rst_n, num, num_valid, clr -> even, odd, out_valid, even_cnt, odd_cnt.
module even_odd_code
  import even_odd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] num,
  input  logic              num_valid,
  input  logic              clr,
  output logic              even,
  output logic              odd,
  output logic              out_valid,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt
);

  logic lsb;
  logic even_inc;
  logic odd_inc;
  logic unused_num;

  // Only the LSB decides parity; upper bits are deliberately ignored.
  assign lsb        = num[0];
  assign unused_num = ^num;

  assign even_inc = num_valid & ~lsb;
  assign odd_inc  = num_valid &  lsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even      <= 1'b0;
      odd       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= num_valid;
      if (num_valid) begin
        even <= ~lsb;
        odd  <=  lsb;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_even_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (even_inc),
    .clr   (clr),
    .cnt   (even_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_odd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (odd_inc),
    .clr   (clr),
    .cnt   (odd_cnt)
  );

endmodule

// File: tb/tb_even_odd_code.sv
// Directed self-checking bench for even_odd_code.
// Drives at edge+1, samples at edge+1 after each rising edge.
module tb_even_odd_code;

  logic        clk;
  logic        rst_n;
  logic [7:0]  num;
  logic        num_valid;
  logic        clr;
  logic        even;
  logic        odd;
  logic        out_valid;
  logic [15:0] even_cnt;
  logic [15:0] odd_cnt;

  int n_cmp;
  int n_bad;

  even_odd_code #(
    .DATA_W (8),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .num_valid (num_valid),
    .clr       (clr),
    .even      (even),
    .odd       (odd),
    .out_valid (out_valid),
    .even_cnt  (even_cnt),
    .odd_cnt   (odd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    num       = v;
    num_valid = 1'b1;
    cyc();
  endtask

  task automatic chk_flags(input string tag,
                           input logic e,
                           input logic o,
                           input logic ov);
    chk({tag, ".even"}, {31'd0, even}, {31'd0, e});
    chk({tag, ".odd"}, {31'd0, odd}, {31'd0, o});
    chk({tag, ".ov"}, {31'd0, out_valid}, {31'd0, ov});
  endtask

  task automatic chk_cnt(input string tag,
                         input logic [15:0] ec,
                         input logic [15:0] oc);
    chk({tag, ".ecnt"}, {16'd0, even_cnt}, {16'd0, ec});
    chk({tag, ".ocnt"}, {16'd0, odd_cnt}, {16'd0, oc});
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    num       = 8'h00;
    num_valid = 1'b0;
    clr       = 1'b0;

    #12;
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    chk_cnt("rst", 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    send(8'h00);
    num_valid = 1'b0;
    chk_flags("zero", 1'b1, 1'b0, 1'b1);
    chk_cnt("zero", 16'd1, 16'd0);

    cyc();
    chk_flags("hold", 1'b1, 1'b0, 1'b0);

    send(8'h01);
    chk_flags("b2b1", 1'b0, 1'b1, 1'b1);
    send(8'h06);
    chk_flags("b2b6", 1'b1, 1'b0, 1'b1);
    send(8'h07);
    num_valid = 1'b0;
    chk_flags("b2b7", 1'b0, 1'b1, 1'b1);
    chk_cnt("b2b", 16'd2, 16'd2);

    send(8'hFE);
    chk_flags("fe", 1'b1, 1'b0, 1'b1);
    send(8'hFF);
    num_valid = 1'b0;
    chk_flags("ff", 1'b0, 1'b1, 1'b1);
    chk_cnt("upper", 16'd3, 16'd3);

    clr = 1'b1;
    send(8'h03);
    clr       = 1'b0;
    num_valid = 1'b0;
    chk_flags("clr", 1'b0, 1'b1, 1'b1);
    chk_cnt("clr", 16'd0, 16'd0);

    for (int i = 0; i < 65535; i++) begin
      send(8'($urandom_range(0, 255)) | 8'h01);
    end
    num_valid = 1'b0;
    chk_cnt("preload", 16'd0, 16'hFFFF);

    send(8'h81);
    num_valid = 1'b0;
    chk_cnt("sat", 16'd0, 16'hFFFF);
    chk_flags("sat", 1'b0, 1'b1, 1'b1);

    send(8'h40);
    num_valid = 1'b0;
    chk_cnt("post_sat", 16'd1, 16'hFFFF);
    chk_flags("post_sat", 1'b1, 1'b0, 1'b1);

    num       = 8'h02;
    num_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_flags("async", 1'b0, 1'b0, 1'b0);
    chk_cnt("async", 16'd0, 16'd0);
    num_valid = 1'b0;
    cyc();
    chk_flags("in_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_flags("rel", 1'b0, 1'b0, 1'b0);

    send(8'h05);
    num_valid = 1'b0;
    chk_flags("first", 1'b0, 1'b1, 1'b1);
    chk_cnt("first", 16'd0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
